seq_control: RTL and testbench

Next-address controller for the 4-bit-slice microprogram sequencer. Each cycle it decodes the 4-bit next-address opcode and the test condition from the microinstruction pipeline register. From these it drives the sequencer's select, file-enable, push/pop, zero and carry-in controls, and the source enables for the D bus. It also owns a loop counter and a shadow stack-depth tracker with sticky overflow/underflow flags. It sits between the pipeline register and the cascaded sequencer slices.

---
 rtl/seq_ctl_pkg.sv | 26 ++
 rtl/seq_ctl_depth.sv | 59 +++++
 rtl/seq_control.sv | 141 ++++++++++++++
 tb/tb_seq_control.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_ctl_pkg.sv
// Shared constants for the microprogram sequencer next-address controller.
`default_nettype none

package seq_ctl_pkg;

    localparam logic [3:0] OP_JZ   = 4'd0;
    localparam logic [3:0] OP_CJS  = 4'd1;
    localparam logic [3:0] OP_JMAP = 4'd2;
    localparam logic [3:0] OP_CJP  = 4'd3;
    localparam logic [3:0] OP_PUSH = 4'd4;
    localparam logic [3:0] OP_CRTN = 4'd5;
    localparam logic [3:0] OP_RPCT = 4'd6;
    localparam logic [3:0] OP_LOOP = 4'd7;
    localparam logic [3:0] OP_LDCT = 4'd8;

    localparam logic [1:0] SEL_PC  = 2'b00;
    localparam logic [1:0] SEL_AR  = 2'b01;
    localparam logic [1:0] SEL_STK = 2'b10;
    localparam logic [1:0] SEL_D   = 2'b11;

    localparam int unsigned DEPTH_W   = 3;
    localparam int unsigned STK_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/seq_ctl_depth.sv
// Shadow stack-depth tracker with sticky overflow/underflow flags.
`default_nettype none

module seq_ctl_depth
    import seq_ctl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               clear_i,
    input  logic               err_clr_i,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               ovf_o,
    output logic               unf_o
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    // A fresh error in the same cycle as err_clr wins over the clear.
    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q & ~err_clr_i;
        unf_d   = unf_q & ~err_clr_i;
        if (clear_i) begin
            depth_d = '0;
        end else if (push_i) begin
            if (depth_q == DEPTH_MAX) ovf_d = 1'b1;
            else                      depth_d = depth_q + DEPTH_ONE;
        end else if (pop_i) begin
            if (depth_q == '0) unf_d = 1'b1;
            else               depth_d = depth_q - DEPTH_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign depth_o = depth_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

`default_nettype wire

// File: rtl/seq_control.sv
// Next-address controller: decodes opcode/condition into sequencer slice
// controls and owns the loop counter and shadow stack depth.
`default_nettype none

module seq_control
    import seq_ctl_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [3:0]         op_i,
    input  logic               cond_i,
    input  logic               cond_en_i,
    input  logic               hold_i,
    input  logic [CW-1:0]      cnt_din_i,
    input  logic               err_clr_i,
    output logic [1:0]         sel_o,
    output logic               fe_n_o,
    output logic               pup_o,
    output logic               zero_n_o,
    output logic               cin_o,
    output logic               pl_oe_o,
    output logic               map_oe_o,
    output logic               cnt_zero_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               ovf_o,
    output logic               unf_o
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pass;
    logic          cnt_nz;
    logic          clear;
    logic          err_clr;
    logic          push;
    logic          pop;

    assign pass   = cond_i | ~cond_en_i;
    assign cnt_nz = (cnt_q != '0);

    always_comb begin
        sel_o    = SEL_PC;
        fe_n_o   = 1'b1;
        pup_o    = 1'b0;
        zero_n_o = 1'b1;
        cin_o    = 1'b1;
        pl_oe_o  = 1'b1;
        map_oe_o = 1'b0;
        cnt_d    = cnt_q;
        clear    = 1'b0;
        err_clr  = err_clr_i;

        unique case (op_i)
            OP_JZ: begin
                zero_n_o = 1'b0;
                clear    = 1'b1;
            end
            OP_CJS: if (pass) begin
                sel_o  = SEL_D;
                fe_n_o = 1'b0;
                pup_o  = 1'b1;
            end
            OP_JMAP: begin
                sel_o    = SEL_D;
                map_oe_o = 1'b1;
                pl_oe_o  = 1'b0;
            end
            OP_CJP: if (pass) sel_o = SEL_D;
            OP_PUSH: begin
                fe_n_o = 1'b0;
                pup_o  = 1'b1;
                if (pass) cnt_d = cnt_din_i;
            end
            OP_CRTN: if (pass) begin
                sel_o  = SEL_STK;
                fe_n_o = 1'b0;
            end
            OP_RPCT: if (cnt_nz) begin
                sel_o = SEL_D;
                cnt_d = cnt_q - CNT_ONE;
            end
            OP_LOOP: begin
                if (pass) fe_n_o = 1'b0;
                else      sel_o  = SEL_STK;
            end
            OP_LDCT: cnt_d = cnt_din_i;
            default: ;
        endcase

        // Stall freezes all state and re-presents the current address.
        if (hold_i) begin
            sel_o    = SEL_PC;
            cin_o    = 1'b0;
            fe_n_o   = 1'b1;
            pup_o    = 1'b0;
            zero_n_o = 1'b1;
            cnt_d    = cnt_q;
            clear    = 1'b0;
            err_clr  = 1'b0;
        end

        // While in reset the sequencer is steered to load address 0.
        if (!rst_ni) begin
            sel_o    = SEL_PC;
            fe_n_o   = 1'b1;
            pup_o    = 1'b0;
            zero_n_o = 1'b0;
            cin_o    = 1'b0;
            pl_oe_o  = 1'b0;
            map_oe_o = 1'b0;
        end
    end

    assign push = ~fe_n_o &  pup_o;
    assign pop  = ~fe_n_o & ~pup_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_zero_o = ~cnt_nz;

    seq_ctl_depth u_depth (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push),
        .pop_i     (pop),
        .clear_i   (clear),
        .err_clr_i (err_clr),
        .depth_o   (depth_o),
        .ovf_o     (ovf_o),
        .unf_o     (unf_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_seq_control.sv
// Table-driven scoreboard bench for seq_control.
`default_nettype none

module tb_seq_control;
    import seq_ctl_pkg::*;

    localparam int CW = 12;

    // Control word: {sel[1:0], fe_n, pup, zero_n, cin, pl_oe, map_oe}
    localparam logic [7:0] C_CONT  = 8'b0010_1110;
    localparam logic [7:0] C_PUSHD = 8'b1101_1110;
    localparam logic [7:0] C_POPS  = 8'b1000_1110;
    localparam logic [7:0] C_D     = 8'b1110_1110;
    localparam logic [7:0] C_JZ    = 8'b0010_0110;
    localparam logic [7:0] C_HOLD  = 8'b0010_1010;
    localparam logic [7:0] C_LOOPF = 8'b1010_1110;
    localparam logic [7:0] C_LOOPP = 8'b0000_1110;
    localparam logic [7:0] C_JMAP  = 8'b1110_1101;
    localparam logic [7:0] C_PUSH0 = 8'b0001_1110;
    localparam logic [7:0] C_RST   = 8'b0010_0000;

    typedef struct {
        logic [3:0]    op;
        logic          cond;
        logic          cond_en;
        logic          hold;
        logic          err_clr;
        logic [CW-1:0] din;
        logic [7:0]    ctl;
        logic [5:0]    st;   // {depth, ovf, unf, cnt_zero} after the edge
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    op;
    logic          cond, cond_en, hold, err_clr;
    logic [CW-1:0] cnt_din;
    logic [1:0]    sel;
    logic          fe_n, pup, zero_n, cin, pl_oe, map_oe, cnt_zero, ovf, unf;
    logic [2:0]    depth;

    int   n_pass = 0;
    int   n_total = 0;
    vec_t sbq[$];
    vec_t tbl[33];

    wire [7:0] ctl_w = {sel, fe_n, pup, zero_n, cin, pl_oe, map_oe};
    wire [5:0] st_w  = {depth, ovf, unf, cnt_zero};

    always #5 clk = ~clk;

    seq_control #(.CW(CW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .op_i       (op),
        .cond_i     (cond),
        .cond_en_i  (cond_en),
        .hold_i     (hold),
        .cnt_din_i  (cnt_din),
        .err_clr_i  (err_clr),
        .sel_o      (sel),
        .fe_n_o     (fe_n),
        .pup_o      (pup),
        .zero_n_o   (zero_n),
        .cin_o      (cin),
        .pl_oe_o    (pl_oe),
        .map_oe_o   (map_oe),
        .cnt_zero_o (cnt_zero),
        .depth_o    (depth),
        .ovf_o      (ovf),
        .unf_o      (unf)
    );

    function automatic vec_t mk(input logic [3:0] o, input logic c, input logic ce,
                                input logic h, input logic ec, input logic [CW-1:0] d,
                                input logic [7:0] ctl, input logic [2:0] dp,
                                input logic ov, input logic un, input logic cz);
        vec_t v;
        v.op = o; v.cond = c; v.cond_en = ce; v.hold = h; v.err_clr = ec;
        v.din = d; v.ctl = ctl; v.st = {dp, ov, un, cz};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic drive(input vec_t v);
        op = v.op; cond = v.cond; cond_en = v.cond_en; hold = v.hold;
        err_clr = v.err_clr; cnt_din = v.din;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input vec_t v, input string nm);
        vec_t e;
        drive(v);
        sbq.push_back(v);
        @(negedge clk);
        e = sbq[0];
        chk({nm, " ctl"}, ctl_w, e.ctl);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({nm, " state"}, {2'b00, st_w}, {2'b00, e.st});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(4'd9, 0, 1, 0, 0, 0, C_CONT,  3'd0, 0, 0, 1);
        tbl[1]  = mk(OP_CJS,  1, 1, 0, 0, 0, C_PUSHD, 3'd1, 0, 0, 1);
        tbl[2]  = mk(OP_CRTN, 1, 1, 0, 0, 0, C_POPS,  3'd0, 0, 0, 1);
        tbl[3]  = mk(OP_CJS,  0, 1, 0, 0, 0, C_CONT,  3'd0, 0, 0, 1);
        tbl[4]  = mk(OP_CRTN, 0, 1, 0, 0, 0, C_CONT,  3'd0, 0, 0, 1);
        tbl[5]  = mk(OP_LDCT, 0, 1, 0, 0, 3, C_CONT,  3'd0, 0, 0, 0);
        tbl[6]  = mk(OP_RPCT, 0, 1, 0, 0, 0, C_D,     3'd0, 0, 0, 0);
        tbl[7]  = mk(OP_RPCT, 0, 1, 0, 0, 0, C_D,     3'd0, 0, 0, 0);
        tbl[8]  = mk(OP_RPCT, 0, 1, 0, 0, 0, C_D,     3'd0, 0, 0, 1);
        tbl[9]  = mk(OP_RPCT, 0, 1, 0, 0, 0, C_CONT,  3'd0, 0, 0, 1);
        tbl[10] = mk(OP_CJS,  1, 1, 0, 0, 0, C_PUSHD, 3'd1, 0, 0, 1);
        tbl[11] = mk(OP_CJS,  1, 1, 0, 0, 0, C_PUSHD, 3'd2, 0, 0, 1);
        tbl[12] = mk(OP_CJS,  1, 1, 0, 0, 0, C_PUSHD, 3'd3, 0, 0, 1);
        tbl[13] = mk(OP_CJS,  1, 1, 0, 0, 0, C_PUSHD, 3'd4, 0, 0, 1);
        tbl[14] = mk(OP_CJS,  1, 1, 0, 0, 0, C_PUSHD, 3'd4, 1, 0, 1);
        tbl[15] = mk(OP_JZ,   0, 1, 0, 0, 0, C_JZ,    3'd0, 1, 0, 1);
        tbl[16] = mk(4'd9,    0, 1, 0, 1, 0, C_CONT,  3'd0, 0, 0, 1);
        tbl[17] = mk(OP_CRTN, 1, 1, 0, 1, 0, C_POPS,  3'd0, 0, 1, 1);
        tbl[18] = mk(4'd9,    0, 1, 0, 1, 0, C_CONT,  3'd0, 0, 0, 1);
        tbl[19] = mk(OP_CJS,  1, 1, 0, 0, 0, C_PUSHD, 3'd1, 0, 0, 1);
        tbl[20] = mk(OP_CJS,  1, 1, 0, 0, 0, C_PUSHD, 3'd2, 0, 0, 1);
        tbl[21] = mk(OP_LDCT, 0, 1, 0, 0, 5, C_CONT,  3'd2, 0, 0, 0);
        tbl[22] = mk(OP_LOOP, 0, 1, 1, 0, 0, C_HOLD,  3'd2, 0, 0, 0);
        tbl[23] = mk(OP_LOOP, 0, 1, 0, 0, 0, C_LOOPF, 3'd2, 0, 0, 0);
        tbl[24] = mk(OP_LOOP, 1, 1, 0, 0, 0, C_LOOPP, 3'd1, 0, 0, 0);
        tbl[25] = mk(OP_JMAP, 0, 1, 0, 0, 0, C_JMAP,  3'd1, 0, 0, 0);
        tbl[26] = mk(OP_CJP,  1, 0, 0, 0, 0, C_D,     3'd1, 0, 0, 0);
        tbl[27] = mk(OP_CJP,  0, 1, 0, 0, 0, C_CONT,  3'd1, 0, 0, 0);
        tbl[28] = mk(OP_CJP,  0, 0, 0, 0, 0, C_D,     3'd1, 0, 0, 0);
        tbl[29] = mk(OP_PUSH, 0, 1, 0, 0, 9, C_PUSH0, 3'd2, 0, 0, 0);
        tbl[30] = mk(OP_PUSH, 1, 1, 0, 0, 0, C_PUSH0, 3'd3, 0, 0, 1);
        tbl[31] = mk(OP_RPCT, 0, 1, 0, 0, 0, C_CONT,  3'd3, 0, 0, 1);
        tbl[32] = mk(OP_CRTN, 0, 0, 0, 0, 0, C_POPS,  3'd2, 0, 0, 1);

        rst_n = 1'b0;
        drive(mk(4'd9, 0, 1, 0, 0, 0, C_CONT, 3'd0, 0, 0, 1));
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctl", ctl_w, C_RST);
        chk("reset state", {2'b00, st_w}, {2'b00, 3'd0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 33; i++) step(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted in the middle of an RPCT cycle with cnt=5, depth=2.
        step(mk(OP_LDCT, 0, 1, 0, 0, 5, C_CONT, 3'd2, 0, 0, 0), "ldct5");
        drive(mk(OP_RPCT, 0, 1, 0, 0, 0, C_D, 3'd2, 0, 0, 0));
        @(negedge clk);
        chk("rpct pre-reset ctl", ctl_w, C_D);
        rst_n = 1'b0;
        #1;
        chk("mid-reset ctl", ctl_w, C_RST);
        chk("mid-reset state", {2'b00, st_w}, {2'b00, 3'd0, 1'b0, 1'b0, 1'b1});
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        op = 4'd9;
        #1;
        chk("post-reset ctl", ctl_w, C_CONT);
        @(posedge clk);
        #1;
        chk("post-reset state", {2'b00, st_w}, {2'b00, 3'd0, 1'b0, 1'b0, 1'b1});
        step(mk(OP_CJS, 1, 1, 0, 0, 0, C_PUSHD, 3'd1, 0, 0, 1), "post-reset cjs");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
